tram_prot_strobe: RTL and testbench
===================================

Name: tram_prot_strobe

Overview:
- Front-end stage that feeds the PAL16R6 protection model (secret_pal) on the Mr. Do board.
- Detects Z80 writes to TRAM (8000-8FFF) and holds the CPU in wait until the WAIT RESET2 condition occurs: vblank, or horizontal counter low 3 bits equal to zero.
- On the trailing edge of the write, issues a single-cycle clock enable and a captured data byte to the PAL.
- Serves CPU reads of the protection port by returning the PAL output ANDed with READ_MASK.

Parameters:
- TRAM_BASE, 16'h8000, base address of the TRAM window.
- TRAM_MASK, 16'hF000, address bits compared against TRAM_BASE.
- PROT_ADDR, 16'h9803, exact read address of the protection port.
- READ_MASK, 8'h7E, mask applied to the PAL output on read.
- WAIT_MAX, 64, maximum number of clk cycles the wait may be held before forced release.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  Z80 address bus.
- cpu_dout  in  8  Z80 write data.
- cpu_wr  in  1  level, high while a Z80 write cycle is active.
- cpu_rd  in  1  level, high while a Z80 read cycle is active.
- hcnt  in  9  horizontal counter.
- vbl  in  1  vertical blank, active high.
- cpu_wait_n  out  1  Z80 WAIT, active low.
- pal_clk_en  out  1  one-cycle enable to the secret_pal clock.
- pal_data  out  8  byte driven to secret_pal i[9:2].
- pal_q  in  8  secret_pal o[19:12].
- prot_dout  out  8  registered read data for PROT_ADDR.
- prot_hit  out  1  high while cpu_rd is active and cpu_addr equals PROT_ADDR; used for the data-bus mux.
- timeout_err  out  1  sticky flag, set when a forced release occurs.

Behaviour:
- Reset values:
  - cpu_wait_n=1, pal_clk_en=0, pal_data=0, prot_dout=0, timeout_err=0.
  - State IDLE, wait counter 0, cpu_wr history register 0.
- Region hit: tram_hit = ((cpu_addr & TRAM_MASK) == TRAM_BASE).
- Write start: the rising edge of cpu_wr, taken as registered-previous low and current high.
- IDLE state:
  - On write start with tram_hit: capture pal_data <= cpu_dout, go to WAIT, and drive cpu_wait_n=0 from the next cycle.
  - A write start without tram_hit is ignored.
- WAIT state:
  - cpu_wait_n=0.
  - The release condition is not evaluated in the entry cycle, so the wait is held for at least 1 cycle.
  - Release when vbl=1 or hcnt[2:0]==3'b000: go to ACTIVE and set cpu_wait_n=1 on the next cycle.
  - The wait counter increments each WAIT cycle. When it reaches WAIT_MAX-1 without a release condition, force release to ACTIVE and set timeout_err=1.
  - If a release condition and the counter limit coincide, treat it as a normal release; timeout_err is not set.
- ACTIVE state:
  - cpu_wait_n=1.
  - On the first cycle with cpu_wr=0, assert pal_clk_en=1 for exactly 1 cycle and return to IDLE.
  - pal_data holds its value through and after the strobe.
- Write interruption: if cpu_wr drops while in WAIT (abnormal), still complete normally. Go to ACTIVE at release and strobe in the following cycle.
- Strobe count: exactly one pal_clk_en per TRAM write, never two.
- New writes while busy: a new write start while not in IDLE is ignored.
- Reads:
  - prot_hit is combinational.
  - When prot_hit=1, prot_dout <= pal_q & READ_MASK, giving 1-cycle latency. Otherwise prot_dout holds.
  - A read in the same cycle as pal_clk_en samples the pre-strobe pal_q.
- Reset mid-operation: return to IDLE with cpu_wait_n=1 in the following cycle. No strobe is issued, pal_data clears to 0, and timeout_err clears.
- timeout_err is cleared only by reset.

Test Plan:
- Normal write: write 8'hA5 to 16'h8123 with hcnt=5 and incrementing, vbl=0.
  - cpu_wait_n is low until the cycle after hcnt[2:0]==0, then high.
  - Drop cpu_wr: pal_clk_en pulses 1 cycle with pal_data=8'hA5.
  - Exactly one pulse.
- vblank release: write 8'hCD at 16'h8FFF with hcnt held at 3'b101 and vbl=1.
  - Wait is held exactly 1 cycle, then released.
  - Strobe carries 8'hCD.
- Non-TRAM writes: write to 16'h9000 and to 16'h7FFF.
  - cpu_wait_n stays 1 and pal_clk_en never asserts.
- Protection read: read 16'h9803 with pal_q=8'hFF, then pal_q=8'h16.
  - prot_dout = 8'h7E, then 8'h16, each 1 cycle after the read.
  - prot_hit is asserted only for that address.
- Timeout: TRAM write with hcnt frozen at 3'b001 and vbl=0.
  - Forced release after WAIT_MAX cycles and timeout_err=1.
  - Strobe still follows cpu_wr fall.
- Reset mid-wait: assert reset during WAIT.
  - Next cycle cpu_wait_n=1, timeout_err=0, pal_data=0.
  - No pal_clk_en is emitted afterwards when cpu_wr falls.

Source files
------------

// File: rtl/tram_prot_strobe.sv
// tram_prot_strobe: front end of the Mr. Do secret_pal protection model.
// Stalls Z80 writes into the TRAM window until the video timing allows the
// PAL to be clocked (vblank, or hcnt[2:0]==0), then emits one PAL clock
// enable with the captured write byte when the write ends. Also returns the
// masked PAL output on reads of the protection port.
module tram_prot_strobe #(
    parameter logic [15:0] TRAM_BASE = 16'h8000,
    parameter logic [15:0] TRAM_MASK = 16'hF000,
    parameter logic [15:0] PROT_ADDR = 16'h9803,
    parameter logic [7:0]  READ_MASK = 8'h7E,
    parameter int          WAIT_MAX  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [8:0]  hcnt,
    input  logic        vbl,
    output logic        cpu_wait_n,
    output logic        pal_clk_en,
    output logic [7:0]  pal_data,
    input  logic [7:0]  pal_q,
    output logic [7:0]  prot_dout,
    output logic        prot_hit,
    output logic        timeout_err
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             wr_prev;

    logic tram_hit;
    logic wr_start;
    logic release_cond;

    assign tram_hit     = ((cpu_addr & TRAM_MASK) == TRAM_BASE);
    assign wr_start     = cpu_wr & ~wr_prev;
    assign release_cond = vbl | (hcnt[2:0] == 3'b000);
    assign prot_hit     = cpu_rd & (cpu_addr == PROT_ADDR);

    // Only the low three counter bits matter for the PAL clock slot.
    logic unused_hcnt;
    assign unused_hcnt = ^hcnt[8:3];

    // Write-stall FSM: capture, hold WAIT, release, then strobe on write end.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            wr_prev     <= 1'b0;
            cpu_wait_n  <= 1'b1;
            pal_clk_en  <= 1'b0;
            pal_data    <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all of them update from the
            // same pre-edge values; a blocking '=' would let later lines see
            // this cycle's new state and silently change the timing.
            wr_prev    <= cpu_wr;
            pal_clk_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_start && tram_hit) begin
                        pal_data   <= cpu_dout;
                        wait_cnt   <= '0;
                        cpu_wait_n <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A genuine release wins over the timeout when both occur.
                    if (release_cond) begin
                        cpu_wait_n <= 1'b1;
                        state      <= S_ACTIVE;
                    end else if (wait_cnt == CNT_LAST) begin
                        cpu_wait_n  <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_ACTIVE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_ACTIVE: begin
                    // Strobe once the CPU has finished its write cycle; a write
                    // that already dropped during WAIT strobes on the first
                    // ACTIVE cycle.
                    if (!cpu_wr) begin
                        pal_clk_en <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    cpu_wait_n <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Protection port read data, registered one cycle after the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            prot_dout <= 8'h00;
        end else if (prot_hit) begin
            prot_dout <= pal_q & READ_MASK;
        end
    end

endmodule

// File: tb/tb_tram_prot_strobe.sv
// Directed testbench for tram_prot_strobe. Inputs change 1 ns after each
// rising edge; outputs are checked at the same point.
module tb_tram_prot_strobe;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [8:0]  hcnt;
    logic        vbl;
    logic        cpu_wait_n;
    logic        pal_clk_en;
    logic [7:0]  pal_data;
    logic [7:0]  pal_q;
    logic [7:0]  prot_dout;
    logic        prot_hit;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    tram_prot_strobe dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .hcnt       (hcnt),
        .vbl        (vbl),
        .cpu_wait_n (cpu_wait_n),
        .pal_clk_en (pal_clk_en),
        .pal_data   (pal_data),
        .pal_q      (pal_q),
        .prot_dout  (prot_dout),
        .prot_hit   (prot_hit),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Count every strobe so double pulses are caught.
    always @(negedge clk) if (pal_clk_en === 1'b1) strobe_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_addr = '0; cpu_dout = '0; cpu_wr = 0; cpu_rd = 0;
        hcnt = '0; vbl = 0; pal_q = '0;
        tick(); tick();
        checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL reset_wait_n got %b want 1", cpu_wait_n); end
        checks++; if (pal_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got %b want 0", pal_clk_en); end
        checks++; if (pal_data !== 8'h00) begin errors++; $display("FAIL reset_pal_data got %h want 00", pal_data); end
        checks++; if (prot_dout !== 8'h00) begin errors++; $display("FAIL reset_prot_dout got %h want 00", prot_dout); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_normal_write();
        int base;
        logic exp_wn;
        base = strobe_cnt;
        cpu_addr = 16'h8123; cpu_dout = 8'hA5; hcnt = 9'd5; vbl = 0; cpu_wr = 1;
        // hcnt 5,6,7,8 seen at edges 1..4; release at edge 4 (8 & 7 == 0).
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_wn = (i == 4);
            checks++; if (cpu_wait_n !== exp_wn) begin errors++; $display("FAIL normal_wait_n[%0d] got %b want %b", i, cpu_wait_n, exp_wn); end
            checks++; if (pal_clk_en !== 1'b0) begin errors++; $display("FAIL normal_early_strobe[%0d] got %b want 0", i, pal_clk_en); end
            hcnt = hcnt + 9'd1;
            cpu_dout = 8'h00;
        end
        tick();
        checks++; if (pal_clk_en !== 1'b0) begin errors++; $display("FAIL normal_strobe_while_wr got %b want 0", pal_clk_en); end
        cpu_wr = 0;
        tick();
        checks++; if (pal_clk_en !== 1'b1) begin errors++; $display("FAIL normal_strobe got %b want 1", pal_clk_en); end
        checks++; if (pal_data !== 8'hA5) begin errors++; $display("FAIL normal_pal_data got %h want a5", pal_data); end
        tick();
        checks++; if (pal_clk_en !== 1'b0) begin errors++; $display("FAIL normal_strobe_len got %b want 0", pal_clk_en); end
        checks++; if (pal_data !== 8'hA5) begin errors++; $display("FAIL normal_pal_data_hold got %h want a5", pal_data); end
        tick(); tick();
        checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL normal_strobe_count got %0d want 1", strobe_cnt - base); end
    endtask

    task automatic test_vblank_release();
        int base;
        base = strobe_cnt;
        cpu_addr = 16'h8FFF; cpu_dout = 8'hCD; hcnt = 9'd5; vbl = 1; cpu_wr = 1;
        tick();
        checks++; if (cpu_wait_n !== 1'b0) begin errors++; $display("FAIL vbl_wait_low got %b want 0", cpu_wait_n); end
        tick();
        checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL vbl_wait_release got %b want 1", cpu_wait_n); end
        cpu_wr = 0;
        tick();
        checks++; if (pal_clk_en !== 1'b1) begin errors++; $display("FAIL vbl_strobe got %b want 1", pal_clk_en); end
        checks++; if (pal_data !== 8'hCD) begin errors++; $display("FAIL vbl_pal_data got %h want cd", pal_data); end
        vbl = 0;
        tick(); tick();
        checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL vbl_strobe_count got %0d want 1", strobe_cnt - base); end
    endtask

    task automatic test_non_tram();
        int base;
        logic [15:0] addrs [2];
        addrs[0] = 16'h9000; addrs[1] = 16'h7FFF;
        base = strobe_cnt;
        hcnt = 9'd3; vbl = 0;
        for (int a = 0; a < 2; a++) begin
            cpu_addr = addrs[a]; cpu_dout = 8'h99; cpu_wr = 1;
            for (int i = 0; i < 5; i++) begin
                tick();
                checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL nontram_wait_n %h[%0d] got %b want 1", addrs[a], i, cpu_wait_n); end
                if (i == 2) cpu_wr = 0;
            end
        end
        checks++; if (strobe_cnt - base !== 0) begin errors++; $display("FAIL nontram_strobe_count got %0d want 0", strobe_cnt - base); end
    endtask

    task automatic test_write_interrupt();
        int base;
        base = strobe_cnt;
        cpu_addr = 16'h8400; cpu_dout = 8'h5A; hcnt = 9'd1; vbl = 0; cpu_wr = 1;
        tick();
        cpu_wr = 0;
        tick();
        checks++; if (cpu_wait_n !== 1'b0) begin errors++; $display("FAIL intr_wait_held got %b want 0", cpu_wait_n); end
        hcnt = 9'd8;
        tick();
        checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL intr_release got %b want 1", cpu_wait_n); end
        checks++; if (pal_clk_en !== 1'b0) begin errors++; $display("FAIL intr_strobe_early got %b want 0", pal_clk_en); end
        tick();
        checks++; if (pal_clk_en !== 1'b1) begin errors++; $display("FAIL intr_strobe got %b want 1", pal_clk_en); end
        checks++; if (pal_data !== 8'h5A) begin errors++; $display("FAIL intr_pal_data got %h want 5a", pal_data); end
        tick(); tick();
        checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL intr_strobe_count got %0d want 1", strobe_cnt - base); end
    endtask

    task automatic test_prot_read();
        cpu_addr = 16'h9803; cpu_rd = 1; pal_q = 8'hFF;
        #1;
        checks++; if (prot_hit !== 1'b1) begin errors++; $display("FAIL prot_hit_on got %b want 1", prot_hit); end
        tick();
        checks++; if (prot_dout !== 8'h7E) begin errors++; $display("FAIL prot_dout_ff got %h want 7e", prot_dout); end
        pal_q = 8'h16;
        tick();
        checks++; if (prot_dout !== 8'h16) begin errors++; $display("FAIL prot_dout_16 got %h want 16", prot_dout); end
        cpu_addr = 16'h9802; pal_q = 8'h00;
        #1;
        checks++; if (prot_hit !== 1'b0) begin errors++; $display("FAIL prot_hit_other_addr got %b want 0", prot_hit); end
        tick();
        checks++; if (prot_dout !== 8'h16) begin errors++; $display("FAIL prot_dout_hold got %h want 16", prot_dout); end
        cpu_addr = 16'h9803; cpu_rd = 0;
        #1;
        checks++; if (prot_hit !== 1'b0) begin errors++; $display("FAIL prot_hit_no_rd got %b want 0", prot_hit); end
        tick();
        checks++; if (prot_dout !== 8'h16) begin errors++; $display("FAIL prot_dout_no_rd got %h want 16", prot_dout); end
        pal_q = 8'h00;
    endtask

    task automatic test_timeout();
        int base;
        logic exp_wn;
        base = strobe_cnt;
        cpu_addr = 16'h8000; cpu_dout = 8'h3C; hcnt = 9'd1; vbl = 0; cpu_wr = 1;
        // Wait low for WAIT_MAX (64) cycles after edges 1..64, forced release at edge 65.
        for (int i = 1; i <= 65; i++) begin
            tick();
            exp_wn = (i == 65);
            if (cpu_wait_n !== exp_wn) begin errors++; $display("FAIL timeout_wait_n[%0d] got %b want %b", i, cpu_wait_n, exp_wn); end
            checks++;
            if (i == 64) begin
                checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err_early got %b want 0", timeout_err); end
            end
        end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set got %b want 1", timeout_err); end
        cpu_wr = 0;
        tick();
        checks++; if (pal_clk_en !== 1'b1) begin errors++; $display("FAIL timeout_strobe got %b want 1", pal_clk_en); end
        checks++; if (pal_data !== 8'h3C) begin errors++; $display("FAIL timeout_pal_data got %h want 3c", pal_data); end
        tick(); tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky got %b want 1", timeout_err); end
        checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL timeout_strobe_count got %0d want 1", strobe_cnt - base); end
    endtask

    task automatic test_reset_mid_wait();
        int base;
        base = strobe_cnt;
        cpu_addr = 16'h8001; cpu_dout = 8'h77; hcnt = 9'd1; vbl = 0; cpu_wr = 1;
        tick(); tick();
        checks++; if (cpu_wait_n !== 1'b0) begin errors++; $display("FAIL rstmid_in_wait got %b want 0", cpu_wait_n); end
        reset = 1'b1;
        tick();
        checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL rstmid_wait_n got %b want 1", cpu_wait_n); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstmid_timeout got %b want 0", timeout_err); end
        checks++; if (pal_data !== 8'h00) begin errors++; $display("FAIL rstmid_pal_data got %h want 00", pal_data); end
        reset = 1'b0; cpu_wr = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL rstmid_after_wait_n[%0d] got %b want 1", i, cpu_wait_n); end
        end
        checks++; if (strobe_cnt - base !== 0) begin errors++; $display("FAIL rstmid_strobe_count got %0d want 0", strobe_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_normal_write();
        test_vblank_release();
        test_non_tram();
        test_write_interrupt();
        test_prot_read();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
